// File: rtl/register_file_dump_reader.sv
// Sweeps a (possibly wrapping) range of register-file entries out over a valid/ready stream.
// Define REGISTER_DUMP_CHECKSUM_EN to build the running checksum on out_checksum.
//
// state | meaning
// IDLE  | waiting for inp_start
// READ  | read port addressed by counter; word captured at the next edge
// HOLD  | word offered on out_valid until inp_ready
// DONE  | one-cycle out_done pulse
module register_file_dump_reader #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset_asynchronous_n,
    input  logic         inp_start,
    input  logic [3:0]   inp_first_address,
    input  logic [3:0]   inp_last_address,
    output logic [3:0]   out_read_address,
    input  logic [W-1:0] inp_read_data,
    output logic         out_valid,
    input  logic         inp_ready,
    output logic [W-1:0] out_data,
    output logic [3:0]   out_index,
    output logic         out_last,
    output logic         out_busy,
    output logic         out_done,
    output logic [W-1:0] out_checksum
);

    typedef enum logic [1:0] {IDLE, READ, HOLD, DONE} state_t;

    state_t       state_q;
    logic [3:0]   addr_q;
    logic [3:0]   last_addr_q;
    logic [3:0]   index_q;
    logic [W-1:0] data_q;
    logic         valid_q;
    logic         last_q;
    logic         busy_q;
    logic         done_q;
    logic [3:0]   addr_d;
    logic         accept;

    // 4-bit counter gives the 15 -> 0 wrap for free
    assign addr_d = addr_q + 4'd1;
    assign accept = (state_q == HOLD) && inp_ready;

    always_ff @(posedge clk or negedge reset_asynchronous_n) begin
        if (!reset_asynchronous_n) begin
            state_q     <= IDLE;
            addr_q      <= 4'd0;
            last_addr_q <= 4'd0;
            index_q     <= 4'd0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (inp_start) begin
                        addr_q      <= inp_first_address;
                        last_addr_q <= inp_last_address;
                        busy_q      <= 1'b1;
                        state_q     <= READ;
                    end
                end
                READ: begin
                    data_q  <= inp_read_data;
                    index_q <= addr_q;
                    last_q  <= (addr_q == last_addr_q);
                    valid_q <= 1'b1;
                    state_q <= HOLD;
                end
                HOLD: begin
                    if (accept) begin
                        valid_q <= 1'b0;
                        if (last_q) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            addr_q  <= addr_d;
                            state_q <= READ;
                        end
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef REGISTER_DUMP_CHECKSUM_EN
    logic [W-1:0] checksum_q;

    // Cleared only by an accepted start, so the final sum survives past out_done
    always_ff @(posedge clk or negedge reset_asynchronous_n) begin
        if (!reset_asynchronous_n) begin
            checksum_q <= '0;
        end else if ((state_q == IDLE) && inp_start) begin
            checksum_q <= '0;
        end else if (accept) begin
            checksum_q <= checksum_q + data_q;
        end
    end

    assign out_checksum = checksum_q;
`else
    assign out_checksum = '0;
`endif

    assign out_read_address = addr_q;
    assign out_valid        = valid_q;
    assign out_data         = data_q;
    assign out_index        = index_q;
    assign out_last         = last_q;
    assign out_busy         = busy_q;
    assign out_done         = done_q;

endmodule

// File: doc/register_file_dump_reader.md
# register_file_dump_reader

Sweeps a contiguous, optionally wrapping range of register-file entries through one register-file read port and streams each word out over a valid/ready interface, tagged with its index. It sits beside the single-cycle processor's 16-entry register file. It gives debug, trace and self-check logic a way to read the full architectural state without touching the datapath. A sweep is one-shot: started by a pulse, ended by a done pulse.

## Interface
Parameters:
- W, 32, register/data width in bits; must match the register file.

Ports:
- clk  input  1  single clock, rising edge.
- reset_asynchronous_n  input  1  reset, asynchronous, active-low.
- inp_start  input  1  sweep request; sampled only in IDLE.
- inp_first_address  input  4  first register index; sampled with inp_start.
- inp_last_address  input  4  last register index; sampled with inp_start.
- out_read_address  output  4  drives the register-file read-port address.
- inp_read_data  input  W  register-file read-port data; combinational from out_read_address.
- out_valid  output  1  out_data/out_index/out_last are valid.
- inp_ready  input  1  consumer accepts the word when out_valid & inp_ready.
- out_data  output  W  captured register word.
- out_index  output  4  index of out_data.
- out_last  output  1  current word is the final word of the sweep.
- out_busy  output  1  high in every state other than IDLE.
- out_done  output  1  one-cycle pulse after the last word is accepted.
- out_checksum  output  W  running sum of emitted words (see Configuration).

## Operation
- States: IDLE, READ, HOLD, DONE.
- IDLE → READ: on inp_start=1.
  - Latch first_address and last_address.
  - Load the address counter with first_address.
  - Clear the checksum.
- READ:
  - out_read_address = address counter.
  - At the clock edge, capture inp_read_data into out_data and the counter into out_index.
  - Set out_last = (counter == last_address).
  - Go to HOLD.
- HOLD:
  - out_valid=1; out_data, out_index and out_last are held stable.
  - No change while inp_ready=0.
  - On inp_ready=1 with out_last=0: increment the counter modulo 16 and go to READ.
  - On inp_ready=1 with out_last=1: go to DONE.
- DONE: out_done=1 for exactly one cycle, then return to IDLE.
- Wrap-around:
  - If first > last, the counter wraps 15 → 0.
  - Word count = ((last − first) mod 16) + 1.
  - first == last emits exactly one word.
- inp_start while busy: ignored. It is not queued.
- out_read_address in IDLE, HOLD and DONE holds the last driven value. The register file may change underneath; only the captured value is emitted.
- Reset, including mid-sweep:
  - State returns to IDLE.
  - out_valid=0, out_busy=0, out_done=0, out_last=0.
  - out_data=0, out_index=0, out_read_address=0, out_checksum=0.
  - Any partially sent sweep is abandoned with no done pulse.

## Timing
- Start sampled at edge T0 → READ during T0..T1 → out_valid high from edge T1.
- Per word: 1 READ cycle plus at least 1 HOLD cycle. Maximum throughput is one word per 2 cycles with inp_ready held high.
- Full 16-word sweep with inp_ready=1: 32 cycles from start to the last handshake. out_done pulses in the following cycle.
- out_busy rises the cycle after start is sampled and falls the cycle after out_done.
- All outputs are registered except out_read_address, which is the counter register and therefore also glitch-free.
- Back-to-back: a start asserted in the first IDLE cycle after DONE is accepted.

## Configuration
- REGISTER_DUMP_CHECKSUM_EN defined:
  - out_checksum accumulates, modulo 2^W, the sum of every word on its accepted handshake.
  - Final value is valid when out_done pulses and is held until the next accepted start.
- Not defined: out_checksum is tied to 0 and no accumulator logic is built. The port list is identical in both cases.

## Test plan
- Reset, then start with first=0, last=15; register file Rn=n·0x11111111; inp_ready=1 → 16 words, indices 0..15, out_last only on index 15, out_done at cycle 33.
- Start with first=14, last=1 (wrap) → indices 14, 15, 0, 1; out_last on 1; 4 handshakes.
- first=last=5, inp_ready low for 7 cycles → out_valid held, out_data=R5 stable for all 7 cycles, exactly one handshake.
- Assert inp_start during a sweep, and drop reset_asynchronous_n after the 3rd word → start ignored; on reset, outputs go to 0 immediately, no out_done, and a fresh sweep works.
- REGISTER_DUMP_CHECKSUM_EN with R0..R3=0xFFFFFFFF, 1, 2, 3, sweep 0..3 → out_checksum=0x00000005 at out_done; without the macro → 0.
